proc_pipe: RTL and testbench

- Parametrised two-stage pipelined integer core; successor to the single-cycle decoder/datapath processor top.
- Accepts 32-bit instructions through a valid/ready handshake and decodes R-type ALU and ADDI.
- Reads a parametrised register file, with forwarding or interlock selected by parameter.
- Emits operands and result through a back-pressured result port; sits between the instruction source and the trace/writeback consumer.

---
 rtl/proc_pipe_if.sv | 29 ++
 rtl/proc_pipe.sv | 185 ++++++++++++++++++
 tb/tb_proc_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_pipe_if.sv
// Instruction and result channels of the proc_pipe core.
// Both channels transfer on a rising edge where valid & ready are high. A raised valid holds its payload
// stable until that transfer. Ready may depend combinationally on valid and on core state.
interface proc_pipe_if #(
  parameter int XLEN = 32
);
  logic [31:0]     ir;
  logic            ir_valid;
  logic            ir_ready;
  logic [XLEN-1:0] a_out;
  logic [XLEN-1:0] b_out;
  logic [XLEN-1:0] w_out;
  logic [4:0]      rd_out;
  logic            wr_out;
  logic            illegal;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     retired;

  modport master (
    output ir, ir_valid, res_ready,
    input  ir_ready, a_out, b_out, w_out, rd_out, wr_out, illegal, res_valid, retired
  );

  modport slave (
    input  ir, ir_valid, res_ready,
    output ir_ready, a_out, b_out, w_out, rd_out, wr_out, illegal, res_valid, retired
  );
endinterface

// File: rtl/proc_pipe.sv
// Two-stage integer core: D captures decoded control and operands, X executes into the result registers
// and writes the register file. It supports R-type ADD/SUB/XOR/OR/AND and ADDI.
module proc_pipe #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int FORWARD = 1
) (
  input logic        clk,
  input logic        boot,
  proc_pipe_if.slave pp
);
  localparam int RW = $clog2(NREG);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND} alu_op_e;

  function automatic logic in_range(input logic [4:0] idx);
    return int'(idx) < NREG;
  endfunction

  logic [6:0] op;
  logic [4:0] rd;
  logic [2:0] f3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] f7;

  assign op  = pp.ir[6:0];
  assign rd  = pp.ir[11:7];
  assign f3  = pp.ir[14:12];
  assign rs1 = pp.ir[19:15];
  assign rs2 = pp.ir[24:20];
  assign f7  = pp.ir[31:25];

  logic            dec_r;
  logic            dec_i;
  logic            dec_legal;
  logic            uses_rs2;
  alu_op_e         dec_alu;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_r   = 1'b0;
    dec_i   = 1'b0;
    dec_alu = ALU_ADD;
    if (op == 7'h33) begin
      case ({f7, f3})
        {7'h00, 3'b000}: begin dec_r = 1'b1; dec_alu = ALU_ADD; end
        {7'h20, 3'b000}: begin dec_r = 1'b1; dec_alu = ALU_SUB; end
        {7'h00, 3'b100}: begin dec_r = 1'b1; dec_alu = ALU_XOR; end
        {7'h00, 3'b110}: begin dec_r = 1'b1; dec_alu = ALU_OR;  end
        {7'h00, 3'b111}: begin dec_r = 1'b1; dec_alu = ALU_AND; end
        default: ;
      endcase
    end else if (op == 7'h13 && f3 == 3'b000) begin
      dec_i = 1'b1;
    end
  end

  assign dec_legal = (dec_r & in_range(rs1) & in_range(rs2) & in_range(rd)) |
                     (dec_i & in_range(rs1) & in_range(rd));
  assign uses_rs2  = (op != 7'h13);
  assign dec_imm   = {{(XLEN-12){pp.ir[31]}}, pp.ir[31:20]};

  logic [XLEN-1:0] rf [NREG];

  logic            d_valid;
  logic            d_legal;
  alu_op_e         d_alu;
  logic [4:0]      d_rd;
  logic [XLEN-1:0] d_a;
  logic [XLEN-1:0] d_b;
  logic            d_wr;
  logic [XLEN-1:0] alu_w;

  logic            res_valid;
  logic            advance;
  logic            accept;
  logic            hit1;
  logic            hit2;
  logic            raw_stall;
  logic [XLEN-1:0] rf1;
  logic [XLEN-1:0] rf2;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;

  assign d_wr = d_valid & d_legal & (d_rd != 5'd0);

  always_comb begin
    alu_w = '0;
    case (d_alu)
      ALU_ADD: alu_w = d_a + d_b;
      ALU_SUB: alu_w = d_a - d_b;
      ALU_XOR: alu_w = d_a ^ d_b;
      ALU_OR:  alu_w = d_a | d_b;
      ALU_AND: alu_w = d_a & d_b;
      default: alu_w = '0;
    endcase
    if (!d_legal) alu_w = '0;
  end

  // Out-of-range indices only occur on illegal instructions; they read as zero.
  assign rf1 = (rs1 != 5'd0 && in_range(rs1)) ? rf[rs1[RW-1:0]] : '0;
  assign rf2 = (rs2 != 5'd0 && in_range(rs2)) ? rf[rs2[RW-1:0]] : '0;

  // d_wr implies d_rd != 0, so x0 never matches and is never bypassed.
  assign hit1      = d_wr & (rs1 == d_rd);
  assign hit2      = d_wr & (rs2 == d_rd);
  assign raw_stall = (FORWARD == 0) && (hit1 || (hit2 && uses_rs2));

  assign opa = ((FORWARD != 0) && hit1) ? alu_w : rf1;
  assign opb = !uses_rs2 ? dec_imm : (((FORWARD != 0) && hit2) ? alu_w : rf2);

  assign advance     = !res_valid | pp.res_ready;
  assign pp.ir_ready = !boot & (advance | !d_valid) & !raw_stall;
  assign accept      = pp.ir_valid & pp.ir_ready;

  always_ff @(posedge clk or posedge boot) begin
    if (boot) begin
      d_valid <= 1'b0;
      d_legal <= 1'b0;
      d_alu   <= ALU_ADD;
      d_rd    <= 5'd0;
      d_a     <= '0;
      d_b     <= '0;
    end else if (accept) begin
      d_valid <= 1'b1;
      d_legal <= dec_legal;
      d_alu   <= dec_alu;
      d_rd    <= rd;
      d_a     <= opa;
      d_b     <= opb;
    end else if (advance) begin
      d_valid <= 1'b0;
    end
  end

  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] w_q;
  logic [4:0]      rd_q;
  logic            wr_q;
  logic            ill_q;
  logic [31:0]     retired_q;

  always_ff @(posedge clk or posedge boot) begin
    if (boot) begin
      res_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      w_q       <= '0;
      rd_q      <= 5'd0;
      wr_q      <= 1'b0;
      ill_q     <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      if (advance) res_valid <= d_valid;
      if (advance && d_valid) begin
        a_q   <= d_a;
        b_q   <= d_b;
        w_q   <= alu_w;
        rd_q  <= d_rd;
        wr_q  <= d_wr;
        ill_q <= !d_legal;
      end
      if (res_valid && pp.res_ready) retired_q <= retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge boot) begin
    if (boot) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (advance && d_wr) begin
      rf[d_rd[RW-1:0]] <= alu_w;
    end
  end

  assign pp.res_valid = res_valid;
  assign pp.a_out     = a_q;
  assign pp.b_out     = b_q;
  assign pp.w_out     = w_q;
  assign pp.rd_out    = rd_q;
  assign pp.wr_out    = wr_q;
  assign pp.illegal   = ill_q;
  assign pp.retired   = retired_q;
endmodule

// File: tb/tb_proc_pipe.sv
// Bench for proc_pipe: a forwarding core and an interlocked core (both NREG=16) checked against
// a sequential ISA model, with directed tables and multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_proc_pipe;
  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int W    = 3*XLEN + 7;
  localparam int NV   = 18;

  logic        clk = 1'b0;
  logic        boot = 1'b1;
  logic [31:0] ir = '0;
  logic        ir_valid = 1'b0;
  logic        res_ready = 1'b0;
  int          sel = 0;

  always #5 clk = ~clk;

  proc_pipe_if #(.XLEN(XLEN)) bus_f ();
  proc_pipe_if #(.XLEN(XLEN)) bus_s ();

  assign bus_f.ir        = ir;
  assign bus_f.ir_valid  = ir_valid & (sel == 0);
  assign bus_f.res_ready = res_ready & (sel == 0);
  assign bus_s.ir        = ir;
  assign bus_s.ir_valid  = ir_valid & (sel == 1);
  assign bus_s.res_ready = res_ready & (sel == 1);

  proc_pipe #(.XLEN(XLEN), .NREG(NREG), .FORWARD(1)) u_fwd (.clk(clk), .boot(boot), .pp(bus_f.slave));
  proc_pipe #(.XLEN(XLEN), .NREG(NREG), .FORWARD(0)) u_stl (.clk(clk), .boot(boot), .pp(bus_s.slave));

  logic            cur_ir_ready, cur_res_valid, cur_wr, cur_ill;
  logic [XLEN-1:0] cur_a, cur_b, cur_w;
  logic [4:0]      cur_rd;
  logic [31:0]     cur_ret;
  logic [W-1:0]    cur_pack;

  assign cur_ir_ready  = (sel == 1) ? bus_s.ir_ready  : bus_f.ir_ready;
  assign cur_res_valid = (sel == 1) ? bus_s.res_valid : bus_f.res_valid;
  assign cur_a         = (sel == 1) ? bus_s.a_out     : bus_f.a_out;
  assign cur_b         = (sel == 1) ? bus_s.b_out     : bus_f.b_out;
  assign cur_w         = (sel == 1) ? bus_s.w_out     : bus_f.w_out;
  assign cur_rd        = (sel == 1) ? bus_s.rd_out    : bus_f.rd_out;
  assign cur_wr        = (sel == 1) ? bus_s.wr_out    : bus_f.wr_out;
  assign cur_ill       = (sel == 1) ? bus_s.illegal   : bus_f.illegal;
  assign cur_ret       = (sel == 1) ? bus_s.retired   : bus_f.retired;
  assign cur_pack      = {cur_ill, cur_wr, cur_rd, cur_w, cur_b, cur_a};

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Sequential architectural model: one register array per core, updated at acceptance.
  logic [XLEN-1:0] mrf [2][32];
  logic [W-1:0]    exp_q[$];
  logic [31:0]     prog_q[$];
  int              cons[2];

  task automatic model_clear();
    exp_q.delete();
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 32; r++) mrf[s][r] = '0;
    cons[0] = 0;
    cons[1] = 0;
  endtask

  task automatic model_exec(input logic [31:0] i, input int s);
    int r1, r2, d;
    logic ok, wr;
    logic [XLEN-1:0] a, b, w;
    r1 = int'(i[19:15]);
    r2 = int'(i[24:20]);
    d  = int'(i[11:7]);
    a  = (r1 < NREG) ? mrf[s][r1] : '0;
    b  = (i[6:0] == 7'h13) ? XLEN'($signed(i[31:20])) : ((r2 < NREG) ? mrf[s][r2] : '0);
    ok = 1'b0;
    w  = '0;
    if (i[6:0] == 7'h33) begin
      case ({i[31:25], i[14:12]})
        10'h000: begin ok = 1'b1; w = a + b; end
        10'h100: begin ok = 1'b1; w = a - b; end
        10'h004: begin ok = 1'b1; w = a ^ b; end
        10'h006: begin ok = 1'b1; w = a | b; end
        10'h007: begin ok = 1'b1; w = a & b; end
        default: ok = 1'b0;
      endcase
      if (r2 >= NREG) ok = 1'b0;
    end else if (i[6:0] == 7'h13 && i[14:12] == 3'b000) begin
      ok = 1'b1;
      w  = a + b;
    end
    if (r1 >= NREG || d >= NREG) ok = 1'b0;
    if (!ok) w = '0;
    wr = ok && (d != 0);
    if (wr) mrf[s][d] = w;
    exp_q.push_back({!ok, wr, 5'(d), w, b, a});
  endtask

  logic [W-1:0] mon_e;

  always @(negedge clk) begin
    if (!boot) begin
      if (cur_res_valid && res_ready) begin
        cons[sel]++;
        if (exp_q.size() == 0) begin
          check("result_unexpected", cur_pack, '0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e[W-1]) check("result_illegal", cur_pack[W-1:2*XLEN], mon_e[W-1:2*XLEN]);
          else            check("result", cur_pack, mon_e);
        end
      end
      if (ir_valid && cur_ir_ready) model_exec(ir, sel);
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {f7, r2, r1, f3, d, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {imm, r1, f3, d, 7'h13};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] d, r1, r2;
    logic [11:0] imm;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [31:0] res;
    d   = 5'($urandom_range(0, 7));
    r1  = 5'($urandom_range(0, 7));
    r2  = 5'($urandom_range(0, 7));
    imm = 12'($urandom);
    f7  = 7'h00;
    f3  = 3'b000;
    case ($urandom_range(0, 9))
      0, 1, 2: res = enc_i(imm, r1, 3'b000, d);
      8:       res = {imm, r1, 3'($urandom), d, 7'h03};
      9:       res = enc_r(7'h00, r2, 5'($urandom_range(16, 31)), 3'b000, d);
      default: begin
        case ($urandom_range(0, 5))
          0: {f7, f3} = {7'h00, 3'b000};
          1: {f7, f3} = {7'h20, 3'b000};
          2: {f7, f3} = {7'h00, 3'b100};
          3: {f7, f3} = {7'h00, 3'b110};
          4: {f7, f3} = {7'h00, 3'b111};
          default: {f7, f3} = {7'h01, 3'b000};
        endcase
        res = enc_r(f7, r2, r1, f3, d);
      end
    endcase
    return res;
  endfunction

  task automatic do_reset();
    boot = 1'b1;
    ir_valid = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk);
    boot = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic [31:0] instr);
    int g;
    g = 0;
    ir = instr;
    ir_valid = 1'b1;
    res_ready = 1'b0;
    @(negedge clk);
    while (!cur_ir_ready && g < 20) begin @(negedge clk); g++; end
    if (g >= 20) check("accept_timeout", 128'(g), 0);
    @(posedge clk);
    #1;
    ir_valid = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!cur_res_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic run_prog(input int rr_pct, output int stalls);
    int guard;
    stalls = 0;
    guard = 0;
    while (prog_q.size() > 0 && guard < 4000) begin
      ir = prog_q[0];
      ir_valid = 1'b1;
      res_ready = ($urandom_range(0, 99) < rr_pct);
      @(negedge clk);
      if (cur_ir_ready) void'(prog_q.pop_front());
      else stalls++;
      @(posedge clk);
      #1;
      guard++;
    end
    ir_valid = 1'b0;
    res_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin @(posedge clk); #1; guard++; end
    res_ready = 1'b0;
    check("prog_drained", 128'(prog_q.size() + exp_q.size()), 0);
  endtask

  typedef struct {
    logic [31:0] ir;
    logic [31:0] a, b, w;
    logic [4:0]  rd;
    logic        wr, ill;
  } vec_t;

  vec_t vt[NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, stalls, acc, unstable;
    logic have_snap;
    logic [W-1:0] snap;

    vt[0]  = '{enc_i(12'd5,    5'd0, 3'b000, 5'd1),  32'h0,        32'h5,        32'h5,        5'd1,  1'b1, 1'b0};
    vt[1]  = '{enc_i(12'hFFF,  5'd0, 3'b000, 5'd1),  32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  1'b1, 1'b0};
    vt[2]  = '{enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd2, 1'b1, 1'b0};
    vt[3]  = '{enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd3), 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b1, 1'b0};
    vt[4]  = '{enc_i(12'h0F0,  5'd0, 3'b000, 5'd4),  32'h0,        32'hF0,       32'hF0,       5'd4,  1'b1, 1'b0};
    vt[5]  = '{enc_i(12'h03C,  5'd0, 3'b000, 5'd5),  32'h0,        32'h3C,       32'h3C,       5'd5,  1'b1, 1'b0};
    vt[6]  = '{enc_r(7'h00, 5'd5, 5'd4, 3'b100, 5'd6), 32'hF0,     32'h3C,       32'hCC,       5'd6,  1'b1, 1'b0};
    vt[7]  = '{enc_r(7'h00, 5'd5, 5'd4, 3'b110, 5'd7), 32'hF0,     32'h3C,       32'hFC,       5'd7,  1'b1, 1'b0};
    vt[8]  = '{enc_r(7'h00, 5'd5, 5'd4, 3'b111, 5'd8), 32'hF0,     32'h3C,       32'h30,       5'd8,  1'b1, 1'b0};
    vt[9]  = '{{7'h00, 5'd0, 5'd0, 3'b000, 5'd4, 7'h03}, 32'h0,    32'h0,        32'h0,        5'd4,  1'b0, 1'b1};
    vt[10] = '{enc_r(7'h00, 5'd0, 5'd4, 3'b000, 5'd9), 32'hF0,     32'h0,        32'hF0,       5'd9,  1'b1, 1'b0};
    vt[11] = '{enc_r(7'h00, 5'd1, 5'd20, 3'b000, 5'd5), 32'h0,     32'h0,        32'h0,        5'd5,  1'b0, 1'b1};
    vt[12] = '{enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd10), 32'h3C,    32'h0,        32'h3C,       5'd10, 1'b1, 1'b0};
    vt[13] = '{enc_r(7'h01, 5'd5, 5'd4, 3'b000, 5'd6), 32'h0,      32'h0,        32'h0,        5'd6,  1'b0, 1'b1};
    vt[14] = '{enc_i(12'h001,  5'd0, 3'b010, 5'd7),  32'h0,        32'h0,        32'h0,        5'd7,  1'b0, 1'b1};
    vt[15] = '{enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd0), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd0, 1'b0, 1'b0};
    vt[16] = '{enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd11), 32'h0,     32'h0,        32'h0,        5'd11, 1'b1, 1'b0};
    vt[17] = '{enc_i(12'h800,  5'd0, 3'b000, 5'd12), 32'h0,        32'hFFFFF800, 32'hFFFFF800, 5'd12, 1'b1, 1'b0};

    do_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check($sformatf("reset_outputs_%0d", s), {cur_res_valid, cur_pack, cur_ret}, '0);
      check($sformatf("reset_ir_ready_%0d", s), cur_ir_ready, 1);
    end

    // Directed table on the forwarding core, one instruction in flight at a time.
    sel = 0;
    do_reset();
    for (int k = 0; k < NV; k++) begin
      issue_one(vt[k].ir);
      wait_result(cyc);
      check($sformatf("vec%0d.latency", k), 128'(cyc), 1);
      check($sformatf("vec%0d.w", k), cur_w, vt[k].w);
      check($sformatf("vec%0d.rd", k), cur_rd, vt[k].rd);
      check($sformatf("vec%0d.wr", k), cur_wr, vt[k].wr);
      check($sformatf("vec%0d.illegal", k), cur_ill, vt[k].ill);
      if (!vt[k].ill) begin
        check($sformatf("vec%0d.a", k), cur_a, vt[k].a);
        check($sformatf("vec%0d.b", k), cur_b, vt[k].b);
      end
      consume();
      if (k == 0) check("retired_first", cur_ret, 1);
    end
    check("retired_table", cur_ret, NV);

    // Back-to-back RAW pair: no bubble with bypass, exactly one without.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      do_reset();
      prog_q.push_back(enc_i(12'hFFF, 5'd0, 3'b000, 5'd1));
      prog_q.push_back(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2));
      run_prog(100, stalls);
      check($sformatf("raw_bubbles_%0d", s), 128'(stalls), (s == 0) ? 0 : 1);
    end

    // Back-pressure: three offered over four frozen cycles, only two enter.
    sel = 0;
    do_reset();
    prog_q.push_back(enc_i(12'd7, 5'd0, 3'b000, 5'd12));
    prog_q.push_back(enc_i(12'd9, 5'd0, 3'b000, 5'd13));
    prog_q.push_back(enc_r(7'h00, 5'd12, 5'd13, 3'b000, 5'd14));
    acc = 0;
    unstable = 0;
    have_snap = 1'b0;
    snap = '0;
    res_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ir = prog_q[0];
      ir_valid = 1'b1;
      @(negedge clk);
      if (cur_ir_ready) begin void'(prog_q.pop_front()); acc++; end
      if (cur_res_valid) begin
        if (!have_snap) begin snap = cur_pack; have_snap = 1'b1; end
        else if (cur_pack !== snap) unstable++;
      end else if (have_snap) begin
        unstable++;
      end
      @(posedge clk);
      #1;
    end
    ir_valid = 1'b0;
    check("bp_accepted", 128'(acc), 2);
    check("bp_held", have_snap, 1);
    check("bp_unstable", 128'(unstable), 0);
    run_prog(100, stalls);
    check("bp_retired", cur_ret, 3);

    // Asynchronous boot with a result pending, then registers read back as zero.
    sel = 0;
    do_reset();
    issue_one(enc_i(12'd3, 5'd0, 3'b000, 5'd1));
    wait_result(cyc);
    consume();
    issue_one(enc_i(12'd4, 5'd0, 3'b000, 5'd2));
    wait_result(cyc);
    check("boot_pre_valid", cur_res_valid, 1);
    #2;
    boot = 1'b1;
    #1;
    check("boot_async_outputs", {cur_res_valid, cur_pack, cur_ret}, '0);
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk);
    boot = 1'b0;
    @(posedge clk);
    #1;
    issue_one(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
    wait_result(cyc);
    check("boot_add_w", cur_w, 0);
    check("boot_add_ab", {cur_a, cur_b}, 0);
    consume();

    // Randomised programs on both cores against the sequential model.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      do_reset();
      for (int n = 0; n < 200; n++) prog_q.push_back(rand_instr());
      run_prog(70, stalls);
      check($sformatf("rand_retired_%0d", s), cur_ret, 128'(cons[s]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
